// File: rtl/mem_arbiter.sv
// mem_arbiter: three-requester (CPU, Acl, DMA) arbiter in front of a
// single-ported memory with a one-cycle read latency.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   {CPU,Acl,DMA}Req/WrEn/Addr/Data request side, held until granted
//   {CPU,Acl,DMA}Gnt                combinational one-hot grant
//   {CPU,Acl,DMA}Out                registered read data (holds last read)
//   {CPU,Acl,DMA}Valid              completion pulse, 2 cycles after grant
//   MemEn/MemWrEn/MemAddr/MemWData  memory command, issued in grant cycle
//   MemRData                        memory read data, cycle after command
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority CPU > Acl > DMA.

// Per-requester read-data holding register.
module mem_arb_lane #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cap,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] out
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   out <= '0;
    else if (cap) out <= rdata;
endmodule

module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  CPUReq,
  input  logic                  CPUWrEn,
  input  logic [ADDR_WIDTH-1:0] CPUAddr,
  input  logic [DATA_WIDTH-1:0] CPUData,
  output logic                  CPUGnt,
  output logic [DATA_WIDTH-1:0] CPUOut,
  output logic                  CPUValid,
  input  logic                  AclReq,
  input  logic                  AclWrEn,
  input  logic [ADDR_WIDTH-1:0] AclAddr,
  input  logic [DATA_WIDTH-1:0] AclData,
  output logic                  AclGnt,
  output logic [DATA_WIDTH-1:0] AclOut,
  output logic                  AclValid,
  input  logic                  DMAReq,
  input  logic                  DMAWrEn,
  input  logic [ADDR_WIDTH-1:0] DMAAddr,
  input  logic [DATA_WIDTH-1:0] DMAData,
  output logic                  DMAGnt,
  output logic [DATA_WIDTH-1:0] DMAOut,
  output logic                  DMAValid,
  output logic                  MemEn,
  output logic                  MemWrEn,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWData,
  input  logic [DATA_WIDTH-1:0] MemRData
);
  localparam int NUM_LANES = 3;
  localparam int STAGES    = 2;
  localparam int CPU = 0, ACL = 1, DMA = 2;

  typedef struct packed {
    logic                  en;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } cmd_t;

  logic [NUM_LANES-1:0]                 req, wr, arb, gnt, cap;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] addr;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] wdata, out;
  cmd_t                                 mem;

  assign req   = {DMAReq,  AclReq,  CPUReq};
  assign wr    = {DMAWrEn, AclWrEn, CPUWrEn};
  assign addr  = {DMAAddr, AclAddr, CPUAddr};
  assign wdata = {DMAData, AclData, CPUData};

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // ptr names the requester searched first; it moves past each winner.
  logic [1:0] ptr;

  always_comb begin
    arb = '0;
    case (ptr)
      2'd1: begin
        if      (req[ACL]) arb[ACL] = 1'b1;
        else if (req[DMA]) arb[DMA] = 1'b1;
        else if (req[CPU]) arb[CPU] = 1'b1;
      end
      2'd2: begin
        if      (req[DMA]) arb[DMA] = 1'b1;
        else if (req[CPU]) arb[CPU] = 1'b1;
        else if (req[ACL]) arb[ACL] = 1'b1;
      end
      default: begin
        if      (req[CPU]) arb[CPU] = 1'b1;
        else if (req[ACL]) arb[ACL] = 1'b1;
        else if (req[DMA]) arb[DMA] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)        ptr <= 2'd0;
    else if (gnt[CPU]) ptr <= 2'd1;
    else if (gnt[ACL]) ptr <= 2'd2;
    else if (gnt[DMA]) ptr <= 2'd0;
`else
  always_comb begin
    arb = '0;
    if      (req[CPU]) arb[CPU] = 1'b1;
    else if (req[ACL]) arb[ACL] = 1'b1;
    else if (req[DMA]) arb[DMA] = 1'b1;
  end
`endif

  // Grant is combinational, so force it low while reset is held.
  assign gnt = {NUM_LANES{rst_n}} & arb;

  always_comb begin
    mem = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (gnt[i]) begin
        mem.en   = 1'b1;
        mem.wr   = wr[i];
        mem.addr = addr[i];
        mem.data = wdata[i];
      end
  end

  assign MemEn    = mem.en;
  assign MemWrEn  = mem.wr;
  assign MemAddr  = mem.addr;
  assign MemWData = mem.data;

  // One-hot tag pipeline. The write flag is only needed in stage 1, where
  // it decides whether MemRData is captured; stage 2 just raises Valid.
  logic [STAGES:1][NUM_LANES-1:0] vld_pipe;
  logic                           wr_s1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe <= '0;
      wr_s1    <= 1'b0;
    end else begin
      vld_pipe[1] <= gnt;
      wr_s1       <= mem.wr;
      for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
    end

  assign cap = vld_pipe[1] & {NUM_LANES{~wr_s1}};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mem_arb_lane #(.DW(DATA_WIDTH)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .cap  (cap[i]),
      .rdata(MemRData),
      .out  (out[i])
    );
  end

  assign CPUGnt   = gnt[CPU];
  assign AclGnt   = gnt[ACL];
  assign DMAGnt   = gnt[DMA];
  assign CPUOut   = out[CPU];
  assign AclOut   = out[ACL];
  assign DMAOut   = out[DMA];
  assign CPUValid = vld_pipe[STAGES][CPU];
  assign AclValid = vld_pipe[STAGES][ACL];
  assign DMAValid = vld_pipe[STAGES][DMA];
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter. Lane order in packed
// fields is {DMA, Acl, CPU}. Expectations follow the build macro.
module tb_mem_arbiter;
  localparam int DW = 32, AW = 16, NV = 31;

  logic clk, rst_n;
  logic CPUReq, CPUWrEn, CPUGnt, CPUValid;
  logic AclReq, AclWrEn, AclGnt, AclValid;
  logic DMAReq, DMAWrEn, DMAGnt, DMAValid;
  logic [AW-1:0] CPUAddr, AclAddr, DMAAddr, MemAddr;
  logic [DW-1:0] CPUData, AclData, DMAData, CPUOut, AclOut, DMAOut;
  logic MemEn, MemWrEn;
  logic [DW-1:0] MemWData, MemRData;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .CPUReq(CPUReq), .CPUWrEn(CPUWrEn), .CPUAddr(CPUAddr), .CPUData(CPUData),
    .CPUGnt(CPUGnt), .CPUOut(CPUOut), .CPUValid(CPUValid),
    .AclReq(AclReq), .AclWrEn(AclWrEn), .AclAddr(AclAddr), .AclData(AclData),
    .AclGnt(AclGnt), .AclOut(AclOut), .AclValid(AclValid),
    .DMAReq(DMAReq), .DMAWrEn(DMAWrEn), .DMAAddr(DMAAddr), .DMAData(DMAData),
    .DMAGnt(DMAGnt), .DMAOut(DMAOut), .DMAValid(DMAValid),
    .MemEn(MemEn), .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Small memory: unwritten locations read back as {C0DE, addr}.
  logic [DW-1:0] mem [16];
  logic [15:0]   wrote;
  function automatic logic [3:0] hidx(input logic [AW-1:0] a);
    return a[11:8] ^ a[3:0];
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) wrote <= '0;
    else if (MemEn) begin
      if (MemWrEn) begin
        mem[hidx(MemAddr)]   <= MemWData;
        wrote[hidx(MemAddr)] <= 1'b1;
      end else
        MemRData <= wrote[hidx(MemAddr)] ? mem[hidx(MemAddr)] : {16'hC0DE, MemAddr};
    end

  logic [2:0]         gnt_o, vld_o;
  logic [2:0][DW-1:0] out_o;
  assign gnt_o = {DMAGnt, AclGnt, CPUGnt};
  assign vld_o = {DMAValid, AclValid, CPUValid};
  assign out_o = {DMAOut, AclOut, CPUOut};

  typedef struct {
    logic [2:0]         req, wr;
    logic [2:0][AW-1:0] addr;
    logic [2:0][DW-1:0] data;
    logic [2:0]         gnt;
    logic               men, mwr;
    logic [AW-1:0]      maddr;
    logic [DW-1:0]      mwd;
    logic [2:0]         vld, omask;
    logic [2:0][DW-1:0] out;
  } vec_t;

  vec_t vt [NV];
  int   n_chk = 0, n_fail = 0;

  function automatic vec_t mk(
    input logic [2:0] req, wr, input logic [AW-1:0] a0, a1, a2,
    input logic [DW-1:0] d0, d1, d2, input logic [2:0] gnt,
    input logic men, mwr, input logic [AW-1:0] maddr, input logic [DW-1:0] mwd,
    input logic [2:0] vld, omask, input logic [DW-1:0] o0, o1, o2);
    vec_t v;
    v.req = req; v.wr = wr; v.addr = {a2, a1, a0}; v.data = {d2, d1, d0};
    v.gnt = gnt; v.men = men; v.mwr = mwr; v.maddr = maddr; v.mwd = mwd;
    v.vld = vld; v.omask = omask; v.out = {o2, o1, o0};
    return v;
  endfunction

  function automatic vec_t idl(input logic [2:0] vld, omask,
                               input logic [DW-1:0] o0, o1, o2);
    return mk(3'b0, 3'b0, '0, '0, '0, '0, '0, '0, 3'b0, 1'b0, 1'b0, '0, '0,
              vld, omask, o0, o1, o2);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [2:0] req, wr,
                     input logic [2:0][AW-1:0] a, input logic [2:0][DW-1:0] d);
    {DMAReq, AclReq, CPUReq}    = req;
    {DMAWrEn, AclWrEn, CPUWrEn} = wr;
    {DMAAddr, AclAddr, CPUAddr} = a;
    {DMAData, AclData, CPUData} = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " gnt"}, 64'(gnt_o), 64'd0);
    chk({tag, " memen"}, 64'(MemEn), 64'd0);
    chk({tag, " memwr"}, 64'(MemWrEn), 64'd0);
    chk({tag, " memaddr"}, 64'(MemAddr), 64'd0);
    chk({tag, " memwdata"}, 64'(MemWData), 64'd0);
    chk({tag, " valid"}, 64'(vld_o), 64'd0);
    for (int j = 0; j < 3; j++) chk($sformatf("%s out%0d", tag, j), 64'(out_o[j]), 64'd0);
  endtask

  initial begin
    logic [2:0] g [6];
    logic [DW-1:0] dma_last;

    // Simultaneous reads, then CPU write/read, Acl write/read.
    vt[0]  = mk(3'b111, 3'b000, 16'h0100, 16'h0200, 16'h0300, 0, 0, 0,
                3'b001, 1, 0, 16'h0100, 0, 3'b000, 3'b000, 0, 0, 0);
    vt[1]  = mk(3'b110, 3'b000, 0, 16'h0200, 16'h0300, 0, 0, 0,
                3'b010, 1, 0, 16'h0200, 0, 3'b000, 3'b000, 0, 0, 0);
    vt[2]  = mk(3'b100, 3'b000, 0, 0, 16'h0300, 0, 0, 0,
                3'b100, 1, 0, 16'h0300, 0, 3'b001, 3'b001, 32'hC0DE0100, 0, 0);
    vt[3]  = idl(3'b010, 3'b010, 0, 32'hC0DE0200, 0);
    vt[4]  = idl(3'b100, 3'b100, 0, 0, 32'hC0DE0300);
    vt[5]  = mk(3'b001, 3'b001, 16'h1234, 0, 0, 32'hDEADBEEF, 0, 0,
                3'b001, 1, 1, 16'h1234, 32'hDEADBEEF, 3'b000, 3'b000, 0, 0, 0);
    vt[6]  = mk(3'b001, 3'b000, 16'h1234, 0, 0, 0, 0, 0,
                3'b001, 1, 0, 16'h1234, 0, 3'b000, 3'b000, 0, 0, 0);
    vt[7]  = idl(3'b001, 3'b001, 32'hC0DE0100, 0, 0);
    vt[8]  = idl(3'b001, 3'b001, 32'hDEADBEEF, 0, 0);
    vt[9]  = mk(3'b010, 3'b010, 0, 16'h0010, 0, 0, 32'h0000FFFF, 0,
                3'b010, 1, 1, 16'h0010, 32'h0000FFFF, 3'b000, 3'b000, 0, 0, 0);
    vt[10] = mk(3'b010, 3'b000, 0, 16'h0010, 0, 0, 0, 0,
                3'b010, 1, 0, 16'h0010, 0, 3'b000, 3'b000, 0, 0, 0);
    vt[11] = idl(3'b010, 3'b010, 0, 32'hC0DE0200, 0);
    vt[12] = idl(3'b010, 3'b010, 0, 32'h0000FFFF, 0);

    // CPU and DMA held for 6 cycles; pointer sits at DMA when this starts.
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      g[k] = (k % 2 == 0) ? 3'b100 : 3'b001;
`else
      g[k] = 3'b001;
`endif
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    dma_last = 32'hC0DE0500;
`else
    dma_last = 32'hC0DE0300;
`endif
    for (int k = 0; k < 6; k++) begin
      vt[13+k] = mk(3'b101, 3'b000, 16'h0400, 0, 16'h0500, 0, 0, 0,
                    g[k], 1, 0, (g[k] == 3'b100) ? 16'h0500 : 16'h0400, 0,
                    3'b000, 3'b000, 0, 0, 0);
      if (k >= 2) vt[13+k].vld = g[k-2];
    end
    vt[19] = idl(g[4], 3'b000, 0, 0, 0);
    vt[20] = idl(g[5], 3'b000, 0, 0, 0);
    for (int k = 21; k < NV; k++)
      vt[k] = idl(3'b000, 3'b111, 32'hC0DE0400, 32'h0000FFFF, dma_last);

    // Reset with all requesters asking: everything must stay 0.
    rst_n = 1'b0;
    drv(3'b111, 3'b111, {16'h3333, 16'h2222, 16'h1111}, {32'h3, 32'h2, 32'h1});
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drv(vt[i].req, vt[i].wr, vt[i].addr, vt[i].data);
      @(negedge clk);
      chk($sformatf("v%0d gnt", i), 64'(gnt_o), 64'(vt[i].gnt));
      chk($sformatf("v%0d memen", i), 64'(MemEn), 64'(vt[i].men));
      chk($sformatf("v%0d memwr", i), 64'(MemWrEn), 64'(vt[i].mwr));
      chk($sformatf("v%0d memaddr", i), 64'(MemAddr), 64'(vt[i].maddr));
      chk($sformatf("v%0d memwdata", i), 64'(MemWData), 64'(vt[i].mwd));
      chk($sformatf("v%0d valid", i), 64'(vld_o), 64'(vt[i].vld));
      for (int j = 0; j < 3; j++)
        if (vt[i].omask[j])
          chk($sformatf("v%0d out%0d", i, j), 64'(out_o[j]), 64'(vt[i].out[j]));
      @(posedge clk); #1;
    end

    // DMA read granted, then reset while it is in flight.
    drv(3'b100, 3'b000, {16'h0300, 16'h0, 16'h0}, '0);
    @(negedge clk);
    chk("mid dma gnt", 64'(gnt_o), 64'b100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drv(3'b111, 3'b111, {16'h3333, 16'h2222, 16'h1111}, {32'h3, 32'h2, 32'h1});
    @(negedge clk);
    chk_zero("mid rst0");
    @(posedge clk); #1;
    @(negedge clk);
    chk_zero("mid rst1");
    @(posedge clk); #1;
    rst_n = 1'b1;
    drv(3'b000, 3'b000, '0, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post rst%0d valid", k), 64'(vld_o), 64'd0);
      @(posedge clk); #1;
    end

    // Arbitration resumes with pointer back at CPU.
    drv(3'b111, 3'b000, {16'h0300, 16'h0200, 16'h0100}, '0);
    @(negedge clk);
    chk("resume gnt", 64'(gnt_o), 64'b001);
    chk("resume memaddr", 64'(MemAddr), 64'h0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 DATA_WIDTH, default 32, width of the data words for all requesters and the memory port.
REQ-002 ADDR_WIDTH, default 16, width of the addresses for all requesters and the memory port.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 For each requester X in {CPU, Acl, DMA}, the block SHALL provide the following ports.
REQ-006 XReq  input  1  request; held high with fields stable until granted.
REQ-007 XWrEn  input  1  1 = write, 0 = read.
REQ-008 XAddr  input  ADDR_WIDTH  request address.
REQ-009 XData  input  DATA_WIDTH  write data.
REQ-010 XGnt  output  1  combinational grant, one-hot across requesters.
REQ-011 XOut  output  DATA_WIDTH  registered read data; holds its last read value.
REQ-012 XValid  output  1  one-cycle completion pulse.
REQ-013 MemEn  output  1  memory command strobe.
REQ-014 MemWrEn  output  1  memory write enable.
REQ-015 MemAddr  output  ADDR_WIDTH  memory address.
REQ-016 MemWData  output  DATA_WIDTH  memory write data.
REQ-017 MemRData  input  DATA_WIDTH  memory read data, valid the cycle after a read command.

Function
REQ-018 Each cycle, at most one request SHALL be granted; XGnt SHALL be 1 only if XReq is 1.
REQ-019 The memory command SHALL be issued in the grant cycle: MemEn=1, and MemWrEn/MemAddr/MemWData taken from the granted requester; with no grant, MemEn=0, MemWrEn=0, and address/data are 0.
REQ-020 A two-stage pipeline SHALL carry a one-hot tag and the write flag; stage 1 is the cycle after grant, stage 2 the cycle after that.
REQ-021 Read completion: at the end of stage 1, MemRData SHALL be registered into XOut; XValid=1 in stage 2, i.e. 2 cycles after XGnt.
REQ-022 Write completion: XValid=1 in stage 2; XOut SHALL remain unchanged.
REQ-023 XValid SHALL be a single-cycle pulse per granted request; back-to-back grants SHALL yield back-to-back pulses.
REQ-024 A new grant SHALL be allowed every cycle, including to the same requester; throughput is 1 command per cycle.
REQ-025 Deasserting XReq before grant SHALL have no effect; the request is dropped silently.
REQ-026 Transactions SHALL reach memory in grant order, so a read after a write to the same address returns the written data.
REQ-027 Arbitration SHALL be as defined under Configuration.

Reset
REQ-028 While rst_n=0, every output SHALL be 0: XGnt, XOut, XValid, MemEn, MemWrEn, MemAddr, MemWData.
REQ-029 While rst_n=0, pipeline tags SHALL be cleared and the round-robin pointer set to CPU.
REQ-030 Reset mid-operation SHALL discard in-flight transactions, and no XValid SHALL be emitted for them after release.
REQ-031 Arbitration SHALL resume on the first rising edge after rst_n rises.

Configuration
REQ-032 With macro MEM_ARB_ROUND_ROBIN_EN defined: round-robin; after granting X, the search order SHALL start at the requester following X (CPU->Acl->DMA->CPU).
REQ-033 With MEM_ARB_ROUND_ROBIN_EN defined and no grant in a cycle, the pointer SHALL hold.
REQ-034 Without MEM_ARB_ROUND_ROBIN_EN: fixed priority CPU > Acl > DMA, with no pointer register.

Verification
REQ-035 After reset, CPU writes 0xDEADBEEF to 0x1234, then reads 0x1234 -> CPUGnt in each request cycle; CPUValid 2 cycles after the read grant, with CPUOut=0xDEADBEEF.
REQ-036 Round-robin build, CPU/Acl/DMA reads raised in the same cycle from reset -> grants CPU, Acl, DMA on consecutive cycles; CPUValid, AclValid, DMAValid on those cycles +2.
REQ-037 CPUReq and DMAReq held high for 6 cycles -> round-robin build alternates CPU, DMA; fixed-priority build never grants DMA.
REQ-038 Acl writes 0x0000FFFF to 0x0010, with an Acl read of 0x0010 the next cycle -> AclOut=0x0000FFFF; AclOut unchanged on the write's AclValid pulse.
REQ-039 rst_n driven low the cycle after a DMA read grant -> no DMAValid after release; all outputs 0 during reset.
REQ-040 No requests for 10 cycles -> MemEn=0 and all XValid=0 throughout.
